// File: rtl/snake_step_ctrl_if.sv
// Bus between the step sequencer and the snake occupancy map.
// The sequencer drives the move proposal and commit; the map answers with a self-hit flag.
interface snake_step_ctrl_if #(
  parameter int XW = 3,
  parameter int YW = 3
) ();
  logic                 map_tick;
  logic                 map_eat;
  logic [XW+YW-1:0]     map_head_xy;
  logic [XW+YW-1:0]     map_tail_xy;
  logic [XW-1:0]        map_next_x;
  logic [YW-1:0]        map_next_y;
  logic                 map_will_pop;
  logic                 map_self_hit;

  modport master (
    output map_tick, map_eat, map_head_xy, map_tail_xy,
           map_next_x, map_next_y, map_will_pop,
    input  map_self_hit
  );

  modport slave (
    input  map_tick, map_eat, map_head_xy, map_tail_xy,
           map_next_x, map_next_y, map_will_pop,
    output map_self_hit
  );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake game-step sequencer: steers, checks walls and self-collision, then commits one move.
// Owns the ordered segment ring buffer that supplies head/tail cells to the occupancy map.
module snake_step_ctrl #(
  parameter int XW      = 3,
  parameter int YW      = 3,
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 6,
  parameter int AW      = 4,
  parameter int START_X = 2,
  parameter int START_Y = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic [1:0]           dir_in,
  input  logic [XW-1:0]        food_x,
  input  logic [YW-1:0]        food_y,
  input  logic                 food_valid,
  snake_step_ctrl_if.master    map,
  output logic [XW-1:0]        head_x,
  output logic [YW-1:0]        head_y,
  output logic [AW:0]          length,
  output logic [7:0]           score,
  output logic                 food_eaten,
  output logic                 game_over
);

  localparam int              MAX_LEN = 2 ** AW;
  localparam logic [AW:0]     LEN_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_COMMIT, S_OVER} state_t;

  state_t               r_state, w_state_nxt;
  logic [XW+YW-1:0]     r_ring [MAX_LEN];
  logic [AW-1:0]        r_hd_idx, r_tl_idx;
  logic [AW:0]          r_len;
  logic [7:0]           r_score;
  logic [1:0]           r_dir;
  logic [XW-1:0]        r_nx;
  logic [YW-1:0]        r_ny;
  logic                 r_wall, r_eat, r_grow;

  logic [AW-1:0]        w_hd_nxt;
  logic [XW-1:0]        w_hx, w_nx;
  logic [YW-1:0]        w_hy, w_ny;
  logic [1:0]           w_dir_eff;
  logic                 w_wall, w_eat_hit, w_grow;
  logic                 w_tick, w_eat, w_will_pop, w_food_eaten, w_over;

  assign w_hd_nxt   = r_hd_idx + AW'(1);
  assign {w_hx, w_hy} = r_ring[r_hd_idx];

  // A request for the exact opposite direction is ignored; the snake keeps going.
  assign w_dir_eff  = (dir_in == (r_dir ^ 2'b10)) ? r_dir : dir_in;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_nx   = w_hx;
    w_ny   = w_hy;
    w_wall = 1'b0;
    unique case (w_dir_eff)
      2'b00: begin w_nx = w_hx + XW'(1); w_wall = (w_hx == XW'(GRID_W - 1)); end
      2'b01: begin w_ny = w_hy + YW'(1); w_wall = (w_hy == YW'(GRID_H - 1)); end
      2'b10: begin w_nx = w_hx - XW'(1); w_wall = (w_hx == '0); end
      2'b11: begin w_ny = w_hy - YW'(1); w_wall = (w_hy == '0); end
    endcase
  end

  assign w_eat_hit = food_valid && (r_nx == food_x) && (r_ny == food_y);
  assign w_grow    = w_eat_hit && (r_len < LEN_MAX);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_RUN;
      S_RUN:    if (step)  w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = (r_wall || map.map_self_hit) ? S_OVER : S_COMMIT;
      S_COMMIT: w_state_nxt = S_RUN;
      S_OVER:   w_state_nxt = S_OVER;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_tick       = 1'b0;
    w_eat        = 1'b0;
    w_will_pop   = 1'b0;
    w_food_eaten = 1'b0;
    w_over       = 1'b0;
    unique case (r_state)
      S_CHECK:  w_will_pop = !w_grow;
      S_COMMIT: begin
        w_tick       = 1'b1;
        w_eat        = r_grow;
        w_will_pop   = !r_grow;
        w_food_eaten = r_eat;
      end
      S_OVER:   w_over = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hd_idx <= '0;
      r_tl_idx <= '0;
      r_len    <= (AW+1)'(1);
      r_score  <= '0;
      r_dir    <= 2'b00;
      r_nx     <= '0;
      r_ny     <= '0;
      r_wall   <= 1'b0;
      r_eat    <= 1'b0;
      r_grow   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: if (step) begin
          r_dir  <= w_dir_eff;
          r_nx   <= w_nx;
          r_ny   <= w_ny;
          r_wall <= w_wall;
        end
        S_CHECK: begin
          r_eat  <= w_eat_hit;
          r_grow <= w_grow;
        end
        S_COMMIT: begin
          r_hd_idx <= w_hd_nxt;
          if (r_grow) r_len    <= r_len + (AW+1)'(1);
          else        r_tl_idx <= r_tl_idx + AW'(1);
          if (r_eat && r_score != 8'hFF) r_score <= r_score + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: only the head slot is reset; other slots are never read before a commit writes them.
  always_ff @(posedge clk) begin
    if (reset)                      r_ring[0]        <= {XW'(START_X), YW'(START_Y)};
    else if (r_state == S_COMMIT)   r_ring[w_hd_nxt] <= {r_nx, r_ny};
  end

  assign map.map_tick     = w_tick;
  assign map.map_eat      = w_eat;
  assign map.map_will_pop = w_will_pop;
  assign map.map_head_xy  = r_ring[r_hd_idx];
  assign map.map_tail_xy  = r_ring[r_tl_idx];
  assign map.map_next_x   = r_nx;
  assign map.map_next_y   = r_ny;

  assign head_x     = w_hx;
  assign head_y     = w_hy;
  assign length     = r_len;
  assign score      = r_score;
  assign food_eaten = w_food_eaten;
  assign game_over  = w_over;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scoreboard bench for snake_step_ctrl: a queue-based snake model predicts each step,
// a monitor compares every commit or game-over the DUT presents.
module tb_snake_step_ctrl;
  localparam int XW = 3, YW = 3, GW = 8, GH = 6, AW = 4, SX = 2, SY = 2;
  localparam int MAXL = 16;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, step = 1'b0, food_valid = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic [XW-1:0] food_x = '0;
  logic [YW-1:0] food_y = '0;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [AW:0]   length;
  logic [7:0]    score;
  logic          food_eaten, game_over;

  snake_step_ctrl_if #(.XW(XW), .YW(YW)) m_if ();

  snake_step_ctrl #(.XW(XW), .YW(YW), .GRID_W(GW), .GRID_H(GH), .AW(AW),
                    .START_X(SX), .START_Y(SY)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .dir_in(dir_in),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .map(m_if),
    .head_x(head_x), .head_y(head_y), .length(length), .score(score),
    .food_eaten(food_eaten), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Occupancy map stand-in: starts holding the start cell so it always equals the body set.
  bit occ [8][8];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) occ[i][j] <= 1'b0;
      occ[SX][SY] <= 1'b1;
    end else if (m_if.map_tick) begin
      if (m_if.map_will_pop) occ[m_if.map_tail_xy[5:3]][m_if.map_tail_xy[2:0]] <= 1'b0;
      occ[m_if.map_next_x][m_if.map_next_y] <= 1'b1;
    end
  end
  always_comb begin
    m_if.map_self_hit = occ[m_if.map_next_x][m_if.map_next_y] &&
      !(m_if.map_will_pop && {m_if.map_next_x, m_if.map_next_y} == m_if.map_tail_xy);
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference snake: body as coordinate queues, index 0 is the head.
  int bx[$], by[$];
  int m_dir, m_score;
  bit m_run, m_over;

  typedef struct {
    bit over;
    bit grow;
    bit eaten;
    logic [5:0] head_pre, tail_pre, nxt;
    int len_after, score_after;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset();
    bx = {SX}; by = {SY};
    m_dir = 0; m_score = 0; m_run = 0; m_over = 0;
  endfunction

  function automatic int eff_dir(int d);
    return (d == (m_dir + 2) % 4) ? m_dir : d;
  endfunction

  function automatic int step_dx(int d); return (d == 0) ? 1 : (d == 2) ? -1 : 0; endfunction
  function automatic int step_dy(int d); return (d == 1) ? 1 : (d == 3) ? -1 : 0; endfunction

  function automatic void model_step(int d, int fx, int fy, bit fv);
    exp_t e;
    int nx, ny, len;
    bit wall, eat, grow, hit;
    if (!m_run || m_over) return;
    m_dir = eff_dir(d);
    nx  = bx[0] + step_dx(m_dir);
    ny  = by[0] + step_dy(m_dir);
    len = bx.size();
    wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
    eat  = fv && (nx == fx) && (ny == fy);
    grow = eat && (len < MAXL);
    hit  = 0;
    for (int i = 0; i < len; i++)
      if (bx[i] == nx && by[i] == ny && !(i == len - 1 && !grow)) hit = 1;
    e = '{default: 0};
    if (wall || hit) begin
      m_over = 1; e.over = 1; sb.push_back(e);
      return;
    end
    e.grow     = grow;
    e.eaten    = eat;
    e.head_pre = 6'(bx[0] * 8 + by[0]);
    e.tail_pre = 6'(bx[len-1] * 8 + by[len-1]);
    e.nxt      = 6'(nx * 8 + ny);
    bx.push_front(nx); by.push_front(ny);
    if (!grow) begin void'(bx.pop_back()); void'(by.pop_back()); end
    if (eat && m_score < 255) m_score++;
    e.len_after   = bx.size();
    e.score_after = m_score;
    sb.push_back(e);
  endfunction

  // Monitor: consumes one expectation per commit or per entry into game over.
  initial begin
    exp_t cur;
    bit pend, seen_over;
    pend = 0; seen_over = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; seen_over = 0;
      end else begin
        if (pend) begin
          check("post_head", {head_x, head_y}, cur.nxt);
          check("post_len", length, cur.len_after);
          check("post_score", score, cur.score_after);
          pend = 0;
        end
        if (m_if.map_tick) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_tick: got a commit, expected none (t=%0t)", $time);
          end else begin
            cur = sb.pop_front();
            check("tick_vs_over", cur.over, 1'b0);
            check("map_eat", m_if.map_eat, cur.grow);
            check("map_will_pop", m_if.map_will_pop, !cur.grow);
            check("map_head_xy", m_if.map_head_xy, cur.head_pre);
            check("map_tail_xy", m_if.map_tail_xy, cur.tail_pre);
            check("map_next", {m_if.map_next_x, m_if.map_next_y}, cur.nxt);
            check("food_eaten", food_eaten, cur.eaten);
            pend = 1;
          end
        end
        if (game_over && !seen_over) begin
          seen_over = 1;
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_over: got game_over, expected none (t=%0t)", $time);
          end else begin
            cur = sb.pop_front();
            check("over_expected", cur.over, 1'b1);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; step = 1'b0; start = 1'b0; food_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; m_run = 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_step(input int d, input int fx, input int fy, input bit fv);
    dir_in = 2'(d); food_x = 3'(fx); food_y = 3'(fy); food_valid = fv; step = 1'b1;
    model_step(d, fx, fy, fv);
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic step_eat(input int d);
    do_step(d, bx[0] + step_dx(eff_dir(d)), by[0] + step_dy(eff_dir(d)), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cap_dirs[16] = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2, 2, 2, 1, 0, 0};
    model_reset();
    @(negedge clk);
    do_reset();

    check("rst_game_over", game_over, 1'b0);
    check("rst_length", length, 5'd1);
    check("rst_head", {head_x, head_y}, 6'o22);
    check("rst_score", score, 8'd0);
    check("rst_tick", m_if.map_tick, 1'b0);
    check("rst_next", {m_if.map_next_x, m_if.map_next_y}, 6'o00);

    do_step(0, 0, 0, 0);            // dropped in IDLE
    check("idle_step_head", {head_x, head_y}, 6'o22);
    do_start();
    do_step(0, 0, 0, 0);
    check("first_head", {head_x, head_y}, 6'o32);
    check("first_len", length, 5'd1);

    // Grow, pop, reversal, wall
    do_reset(); do_start();
    do_step(0, 3, 2, 1);
    check("grow_len", length, 5'd2);
    check("grow_score", score, 8'd1);
    do_step(0, 0, 0, 0);
    do_step(2, 0, 0, 0);
    check("reversal_head", {head_x, head_y}, 6'o52);
    do_step(0, 0, 0, 0);
    do_step(0, 0, 0, 0);
    do_step(0, 0, 0, 0);
    check("wall_over", game_over, 1'b1);
    do_step(1, 0, 0, 0);
    check("over_holds", game_over, 1'b1);
    check("over_head", {head_x, head_y}, 6'o72);

    // Tail exception, then mid-body hit
    do_reset(); do_start();
    step_eat(0); step_eat(1); step_eat(2);
    do_step(3, 0, 0, 0);
    check("tail_move_ok", game_over, 1'b0);
    check("tail_move_len", length, 5'd4);
    step_eat(3);
    do_step(0, 0, 0, 0);
    do_step(1, 0, 0, 0);
    do_step(2, 0, 0, 0);
    check("body_hit_over", game_over, 1'b1);

    // Fill to MAX_LEN, then eat once more
    do_reset(); do_start();
    foreach (cap_dirs[i]) step_eat(cap_dirs[i]);
    check("cap_len", length, 5'd16);
    check("cap_score", score, 8'd16);

    // Reset while the step is in CHECK
    dir_in = 2'b00; food_valid = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_len", length, 5'd1);
    check("midreset_head", {head_x, head_y}, 6'o22);
    check("midreset_score", score, 8'd0);
    check("midreset_over", game_over, 1'b0);
    repeat (3) @(negedge clk);

    // Randomized games
    for (int g = 0; g < 25; g++) begin
      do_reset(); do_start();
      for (int s = 0; s < 60 && !m_over; s++) begin
        int d, fx, fy;
        bit fv;
        d  = int'($urandom_range(3));
        fv = 1'($urandom_range(1));
        if ($urandom_range(1) == 1) begin
          fx = bx[0] + step_dx(eff_dir(d));
          fy = by[0] + step_dy(eff_dir(d));
        end else begin
          fx = int'($urandom_range(GW - 1));
          fy = int'($urandom_range(GH - 1));
        end
        do_step(d, fx, fy, fv);
      end
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
